// File: rtl/lcd_pkg.sv
// Shared types, RGB888 colour constants and default 800x480 panel timing
// for the LCD timing driver and its counters.
package lcd_pkg;

  localparam int CNT_W = 11;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [23:0]      pixel_t;
  typedef logic [11:0]      coord_t;

  localparam pixel_t RED    = 24'hFF0000;
  localparam pixel_t GREEN  = 24'h00FF00;
  localparam pixel_t BLUE   = 24'h0000FF;
  localparam pixel_t WHITE  = 24'hFFFFFF;
  localparam pixel_t BLACK  = 24'h000000;
  localparam pixel_t YELLOW = 24'hFFFF00;
  localparam pixel_t CYAN   = 24'h00FFFF;
  localparam pixel_t ROYAL  = 24'h4169E1;

  localparam int LCD_H_DISP  = 800;
  localparam int LCD_H_SYNC  = 1;
  localparam int LCD_H_BACK  = 46;
  localparam int LCD_H_FRONT = 210;
  localparam int LCD_V_DISP  = 480;
  localparam int LCD_V_SYNC  = 5;
  localparam int LCD_V_BACK  = 23;
  localparam int LCD_V_FRONT = 22;

endpackage

// File: rtl/lcd_axis_counter.sv
// One raster axis: wrapping position counter with sync, active-window and
// first-active-position decodes. Used for both horizontal and vertical.
module lcd_axis_counter
  import lcd_pkg::*;
#(
  parameter int SYNC  = 1,
  parameter int BACK  = 46,
  parameter int DISP  = 800,
  parameter int FRONT = 210
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active,
  output logic             first
);

  localparam int   TOTAL  = SYNC + BACK + DISP + FRONT;
  localparam cnt_t LAST   = CNT_W'(TOTAL - 1);
  localparam cnt_t SYNC_E = CNT_W'(SYNC);
  localparam cnt_t ACT_LO = CNT_W'(SYNC + BACK);
  localparam cnt_t ACT_HI = CNT_W'(SYNC + BACK + DISP);

  if (TOTAL >= (1 << CNT_W)) begin : g_bad_total
    $error("lcd_axis_counter: axis total must be below 2048");
  end

  cnt_t cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign count  = cnt_q;
  assign wrap   = en & (cnt_q == LAST);
  assign sync   = (cnt_q < SYNC_E);
  assign active = (cnt_q >= ACT_LO) & (cnt_q < ACT_HI);
  assign first  = (cnt_q == ACT_LO);

endmodule

// File: rtl/lcd_timing_driver.sv
// 800x480 RGB LCD raster timing generator: issues pixel coordinate requests,
// captures returned pixel data and drives panel pins latency-matched.
module lcd_timing_driver
  import lcd_pkg::*;
#(
  parameter int H_DISP       = LCD_H_DISP,
  parameter int H_SYNC       = LCD_H_SYNC,
  parameter int H_BACK       = LCD_H_BACK,
  parameter int H_FRONT      = LCD_H_FRONT,
  parameter int V_DISP       = LCD_V_DISP,
  parameter int V_SYNC       = LCD_V_SYNC,
  parameter int V_BACK       = LCD_V_BACK,
  parameter int V_FRONT      = LCD_V_FRONT,
  parameter int DATA_LATENCY = 1,
  parameter int SYNC_POL     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] lcd_data,
  output logic [11:0] lcd_xpos,
  output logic [11:0] lcd_ypos,
  output logic        lcd_req,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic [23:0] lcd_rgb,
  output logic        frame_start
);

  localparam int   STAGES = DATA_LATENCY + 2;
  localparam cnt_t H_OFS  = CNT_W'(H_SYNC + H_BACK);
  localparam cnt_t V_OFS  = CNT_W'(V_SYNC + V_BACK);
  localparam logic POL    = (SYNC_POL != 0);

  if (DATA_LATENCY < 0 || DATA_LATENCY > 4) begin : g_bad_latency
    $error("lcd_timing_driver: DATA_LATENCY must be in 0..4");
  end

  cnt_t h_cnt, v_cnt;
  logic h_wrap, h_sync, h_act, h_first;
  logic v_wrap_unused, v_sync, v_act, v_first;

  lcd_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .DISP(H_DISP), .FRONT(H_FRONT)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(1'b1),
    .count(h_cnt), .wrap(h_wrap), .sync(h_sync), .active(h_act), .first(h_first)
  );

  lcd_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .DISP(V_DISP), .FRONT(V_FRONT)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(h_wrap),
    .count(v_cnt), .wrap(v_wrap_unused), .sync(v_sync), .active(v_act), .first(v_first)
  );

  logic act, first_px;
  assign act      = h_act & v_act;
  assign first_px = act & h_first & v_first;

  // ---- stage p0: coordinate request to pattern generator ----
  logic   req_p0;
  coord_t xpos_p0, ypos_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_p0  <= 1'b0;
      xpos_p0 <= '0;
      ypos_p0 <= '0;
    end else begin
      req_p0  <= act;
      xpos_p0 <= act ? {1'b0, cnt_t'(h_cnt - H_OFS)} : '0;
      ypos_p0 <= act ? {1'b0, cnt_t'(v_cnt - V_OFS)} : '0;
    end
  end

  assign lcd_req  = req_p0;
  assign lcd_xpos = xpos_p0;
  assign lcd_ypos = ypos_p0;

  // ---- stages p0..p(STAGES-1): sync/enable delay, pixel capture at last stage ----
  logic [STAGES-1:0] hs_p, vs_p, vld_p, first_p;
  pixel_t            rgb_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p    <= '0;
      vs_p    <= '0;
      vld_p   <= '0;
      first_p <= '0;
      rgb_p   <= '0;
    end else begin
      hs_p    <= {hs_p[STAGES-2:0], h_sync};
      vs_p    <= {vs_p[STAGES-2:0], v_sync};
      vld_p   <= {vld_p[STAGES-2:0], act};
      first_p <= {first_p[STAGES-2:0], first_px};
      // Data for this pixel arrives exactly while its enable sits one tap early.
      rgb_p   <= vld_p[STAGES-2] ? lcd_data : '0;
    end
  end

  assign lcd_de      = vld_p[STAGES-1];
  assign lcd_rgb     = rgb_p;
  assign frame_start = first_p[STAGES-1];
  assign lcd_hs      = ~(hs_p[STAGES-1] ^ POL);
  assign lcd_vs      = ~(vs_p[STAGES-1] ^ POL);

endmodule
